// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, pixel code enumeration,
// and the colour map used by the pixel controller.
package vga_pkg;

  // Total number of slots in one line or frame, including blanking
  function automatic int span_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;

  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int VGA_H_TOTAL      = span_total(VGA_H_VIS, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL      = span_total(VGA_V_VIS, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // Pixel codes returned by the Rojobot video port
  typedef enum logic [1:0] {
    PIX_BG   = 2'b00,
    PIX_LINE = 2'b01,
    PIX_RED  = 2'b10,
    PIX_BOT  = 2'b11
  } pix_code_t;

  // Nexys3 8-bit colour: RRR GGG BB
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb_t;

  localparam rgb_t COL_WHITE = '{red: 3'd7, green: 3'd7, blue: 2'd3};
  localparam rgb_t COL_BLACK = '{red: 3'd0, green: 3'd0, blue: 2'd0};
  localparam rgb_t COL_RED   = '{red: 3'd7, green: 3'd0, blue: 2'd0};
  localparam rgb_t COL_GREEN = '{red: 3'd0, green: 3'd7, blue: 2'd0};
  localparam rgb_t COL_BLANK = '{red: 3'd0, green: 3'd0, blue: 2'd0};

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: clock divider producing the pixel enable, horizontal and
// vertical counters, and the combinational raw sync / blank / frame-wrap flags
// decoded from the current counter values.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       blank,
  output logic       frame_wrap
);

  localparam int H_TOTAL   = span_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL   = span_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_S  = H_VIS + H_FP;
  localparam int H_SYNC_E  = H_SYNC_S + H_SYNC - 1;
  localparam int V_SYNC_S  = V_VIS + V_FP;
  localparam int V_SYNC_E  = V_SYNC_S + V_SYNC - 1;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             line_end;
  logic             last_line;

  assign pix_en    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign line_end  = (hcount == 10'(H_TOTAL - 1));
  assign last_line = (vcount == 10'(V_TOTAL - 1));

  assign frame_wrap = line_end && last_line;
  assign hsync_raw  = !((hcount >= 10'(H_SYNC_S)) && (hcount <= 10'(H_SYNC_E)));
  assign vsync_raw  = !((vcount >= 10'(V_SYNC_S)) && (vcount <= 10'(V_SYNC_E)));
  assign blank      = (hcount >= 10'(H_VIS)) || (vcount >= 10'(V_VIS));

  // Pixel-clock divider: wraps every CLK_DIV system clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster position: column advances per pixel, row advances per line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hcount <= '0;
        vcount <= last_line ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_ctrl.sv
// VGA pixel controller for the Rojobot video path. Drives row/column to the
// bot, samples the returned 2-bit pixel code on each pixel enable, maps it to
// Nexys3 colour and registers it together with the syncs so all video outputs
// stay aligned one pixel period behind the row/column counters.
// Optional build macro VGA_BORDER_EN forces the outermost visible rows and
// columns to white for monitor alignment.
module vga_pixel_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] vid_pixel_in,
  output logic [9:0] vid_row,
  output logic [9:0] vid_col,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       frame_start
);

  function automatic rgb_t map_colour(input pix_code_t code);
    case (code)
      PIX_BG:   map_colour = COL_WHITE;
      PIX_LINE: map_colour = COL_BLACK;
      PIX_RED:  map_colour = COL_RED;
      PIX_BOT:  map_colour = COL_GREEN;
      default:  map_colour = COL_BLANK;
    endcase
  endfunction

  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       blank;
  logic       frame_wrap;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .blank      (blank),
    .frame_wrap (frame_wrap)
  );

  assign vid_col = hcount;
  assign vid_row = vcount;

  // ---- stage p0: colour of the pixel currently addressed by the counters
  rgb_t rgb_p0;

`ifdef VGA_BORDER_EN
  logic on_border;
  assign on_border = (hcount == 10'd0) || (hcount == 10'(H_VIS - 1)) ||
                     (vcount == 10'd0) || (vcount == 10'(V_VIS - 1));
`endif

  // Colour map with optional alignment border; blanking always wins
  always_comb begin
    rgb_p0 = map_colour(pix_code_t'(vid_pixel_in));
`ifdef VGA_BORDER_EN
    if (on_border) rgb_p0 = COL_WHITE;
`endif
    if (blank) rgb_p0 = COL_BLANK;
  end

  // ---- stage p1: colour and syncs registered together on the pixel enable
  rgb_t rgb_p1;
  logic hsync_p1;
  logic vsync_p1;
  logic frame_start_p1;

  // Output register; frame_start is a single system-clock pulse at the wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p1         <= COL_BLANK;
      hsync_p1       <= 1'b1;
      vsync_p1       <= 1'b1;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= pix_en && frame_wrap;
      if (pix_en) begin
        rgb_p1   <= rgb_p0;
        hsync_p1 <= hsync_raw;
        vsync_p1 <= vsync_raw;
      end
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign vga_red     = rgb_p1.red;
  assign vga_green   = rgb_p1.green;
  assign vga_blue    = rgb_p1.blue;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_pixel_ctrl.sv
// Testbench for vga_pixel_ctrl. A reduced-raster instance is checked every
// cycle against a time-based reference model; a default-raster instance pins
// the full 640x480 horizontal timing.
module tb_vga_pixel_ctrl;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 10, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;   // 24
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;   // 15
  localparam int FRAME_CLK = HT * VT * CLK_DIV;       // 1440
  localparam int HIST = 16384;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] vid_pixel_in = 2'b00;

  logic [9:0] vid_row, vid_col;
  logic hsync, vsync, frame_start;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;

  logic [9:0] vid_row_d, vid_col_d;
  logic hsync_d, vsync_d, frame_start_d;
  logic [2:0] vga_red_d, vga_green_d;
  logic [1:0] vga_blue_d;

  vga_pixel_ctrl #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .vid_pixel_in(vid_pixel_in),
    .vid_row(vid_row), .vid_col(vid_col), .hsync(hsync), .vsync(vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .frame_start(frame_start)
  );

  vga_pixel_ctrl dut_d (
    .clk(clk), .reset(reset), .vid_pixel_in(vid_pixel_in),
    .vid_row(vid_row_d), .vid_col(vid_col_d), .hsync(hsync_d), .vsync(vsync_d),
    .vga_red(vga_red_d), .vga_green(vga_green_d), .vga_blue(vga_blue_d),
    .frame_start(frame_start_d)
  );

  always #5 clk = ~clk;

  int t = 0;        // clk edges since reset release
  int cyc = 0;      // free-running edge count
  int mode = 0;     // 0 random, 1 constant 01, 2 single green, 3 cycling codes
  logic [1:0] hist [HIST];
  logic run = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  function automatic logic [1:0] code_for(input int p);
    int ph, pv;
    ph = p % HT;
    pv = (p / HT) % VT;
    case (mode)
      1: return 2'b01;
      2: return (pv == 4 && ph == 7) ? 2'b11 : 2'b00;
      3: return 2'(p % 4);
      default: return 2'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] colour_of(input logic [1:0] c);
    case (c)
      2'b00: return 8'hFF;
      2'b01: return 8'h00;
      2'b10: return 8'hE0;
      default: return 8'h1C;
    endcase
  endfunction

  // Driver: the valid code is presented only in the cycle the DUT samples it
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) t++; else t = 0;
      #1;
      if (reset && (t % CLK_DIV == CLK_DIV - 1)) begin
        hist[(t / CLK_DIV) % HIST] = code_for(t / CLK_DIV);
        vid_pixel_in = hist[(t / CLK_DIV) % HIST];
      end else begin
        vid_pixel_in = 2'($urandom);
      end
    end
  end

  // Reference model compare, every cycle
  int k, h, v, p, ph, pv;
  logic ehs, evs, efs;
  logic [7:0] ecol;
  always @(negedge clk) begin
    if (run) begin
      if (!reset) begin
        check("reset_state", {vid_row, vid_col, hsync, vsync, vga_red, vga_green, vga_blue, frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0});
      end else begin
        k = t / CLK_DIV;
        h = k % HT;
        v = (k / HT) % VT;
        if (k == 0) begin
          ehs = 1'b1; evs = 1'b1; ecol = 8'd0;
        end else begin
          p  = k - 1;
          ph = p % HT;
          pv = (p / HT) % VT;
          ehs = !(ph >= H_VIS + H_FP && ph < H_VIS + H_FP + H_SYNC);
          evs = !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC);
          if (ph >= H_VIS || pv >= V_VIS) ecol = 8'd0;
          else if (BORDER && (ph == 0 || ph == H_VIS - 1 || pv == 0 || pv == V_VIS - 1)) ecol = 8'hFF;
          else ecol = colour_of(hist[p % HIST]);
        end
        efs = (t % CLK_DIV == 0) && (k > 0) && (k % (HT * VT) == 0);
        check("vid_col", vid_col, h);
        check("vid_row", vid_row, v);
        check("hsync", hsync, ehs);
        check("vsync", vsync, evs);
        check("colour", {vga_red, vga_green, vga_blue}, ecol);
        check("frame_start", frame_start, efs);
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return hsync;
      1: return hsync_d;
      2: return vsync;
      default: return frame_start;
    endcase
  endfunction

  task automatic wait_level(input string name, input int sel, input logic lvl, input int limit);
    int g = 0;
    while (sig(sel) !== lvl && g < limit) begin
      @(negedge clk);
      g++;
    end
    check({name, "_reached"}, 32'(g < limit), 32'd1);
  endtask

  task automatic measure_low(input string name, input int sel, input int limit,
                             input int modulus, input int exp_fall, input int exp_len);
    int lo = 1;
    wait_level(name, sel, 1'b0, limit);
    check({name, "_fall_edge"}, t % modulus, exp_fall);
    @(negedge clk);
    while (sig(sel) === 1'b0 && lo < limit) begin
      lo++;
      @(negedge clk);
    end
    check({name, "_low_clk"}, lo, exp_len);
  endtask

  task automatic wait_pos(input int r, input int c);
    int g = 0;
    while (!(vid_row == 10'(r) && vid_col == 10'(c)) && g < 3 * FRAME_CLK) begin
      @(negedge clk);
      g++;
    end
    check("position_reached", 32'(g < 3 * FRAME_CLK), 32'd1);
  endtask

  task automatic colour_after(input string name, input int clks, input logic [7:0] exp);
    repeat (clks) @(negedge clk);
    check(name, {vga_red, vga_green, vga_blue}, exp);
  endtask

  int c0;
  initial begin
    #1 reset = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;

    // Counter start and first advances
    @(negedge clk);
    while (t < 4) @(negedge clk);
    check("col_after_edge4", vid_col, 10'd1);
    while (t < 8) @(negedge clk);
    check("col_after_edge8", vid_col, 10'd2);
    check("col_default_after_edge8", vid_col_d, 10'd2);

    // Horizontal sync: reduced raster, then full 640x480 raster
    measure_low("hsync_small", 0, 200, 1000000, 76, 16);
    measure_low("hsync_640", 1, 4000, 1000000, 2628, 384);

    // Vertical sync and frame period on the reduced raster
    measure_low("vsync", 2, 2 * FRAME_CLK, FRAME_CLK, 1060, 192);
    wait_level("frame_start_a", 3, 1'b1, 2 * FRAME_CLK);
    check("frame_start_phase", t % FRAME_CLK, 0);
    c0 = cyc;
    @(negedge clk);
    wait_level("frame_start_b", 3, 1'b1, 2 * FRAME_CLK);
    check("frame_start_period", cyc - c0, FRAME_CLK);

    // Single green pixel at (4,7)
    mode = 2;
    @(negedge clk);
    wait_level("frame_green", 3, 1'b1, 2 * FRAME_CLK);
    wait_pos(4, 7);
    colour_after("green_left_neighbour", 3, 8'hFF);
    colour_after("green_pixel", 1, 8'h1C);
    colour_after("green_right_neighbour", 4, 8'hFF);

    // Successive codes 00/01/10/11 starting at (2,4)
    mode = 3;
    @(negedge clk);
    wait_level("frame_cycle", 3, 1'b1, 2 * FRAME_CLK);
    wait_pos(2, 4);
    colour_after("cycle_white", 4, 8'hFF);
    colour_after("cycle_black", 4, 8'h00);
    colour_after("cycle_red", 4, 8'hE0);
    colour_after("cycle_green", 4, 8'h1C);

    // Constant 01: border behaviour
    mode = 1;
    @(negedge clk);
    wait_level("frame_border", 3, 1'b1, 2 * FRAME_CLK);
    wait_pos(0, 5);
    colour_after("border_top_row", 4, BORDER ? 8'hFF : 8'h00);
    wait_pos(3, 0);
    colour_after("border_left_col", 4, BORDER ? 8'hFF : 8'h00);
    wait_pos(3, 5);
    colour_after("inside_black", 4, 8'h00);
    wait_pos(3, 15);
    colour_after("border_right_col", 4, BORDER ? 8'hFF : 8'h00);
    wait_pos(9, 8);
    colour_after("border_bottom_row", 4, BORDER ? 8'hFF : 8'h00);

    // Random pixel codes for two frames
    mode = 0;
    repeat (2 * FRAME_CLK) @(negedge clk);

    // Mid-frame asynchronous reset
    wait_pos(5, 10);
    #2 reset = 1'b0;
    #1 check("async_reset_clear", {vid_row, vid_col, hsync, vsync, vga_red, vga_green, vga_blue, frame_start},
             {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("restart_col", vid_col, 10'd0);
    wait_level("frame_after_reset", 3, 1'b1, 2 * FRAME_CLK);
    check("frame_start_after_reset", t, FRAME_CLK);
    repeat (300) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
